// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer:
// default word width and the output-buffer state encoding.
package sipo_deser_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_e;

endpackage : sipo_deser_pkg

// File: rtl/sipo_deser_bit_cntr.sv
// Modulo-WIDTH bit position counter. wrap flags the edge on which the
// last bit of a word is being taken.
module bit_cntr #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             res,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en) begin
         // Explicit wrap keeps the counter correct even if CNT_W is wider.
         count_q <= (count_q == LAST) ? '0 : count_q + CNT_W'(1);
      end
   end

   assign count = count_q;
   assign wrap  = en && (count_q == LAST);

endmodule : bit_cntr

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer: shifts d in LSB first on each en strobe and
// hands completed words to a consumer through a one-deep output buffer.
module sipo_deser
   import sipo_deser_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             res,
   input  logic             en,
   input  logic             d,
   input  logic             clr,
   input  logic             ready,
   output logic [WIDTH-1:0] out,
   output logic             valid,
   output logic             ovr
);

   // Handshake: valid=1 means out holds a word not yet consumed. A word is
   // consumed on any edge where valid=1 and ready=1; ready is ignored while
   // valid=0. A word completing while valid=1 and ready=0 is dropped and ovr
   // latches until clr or res.

   buf_state_e       state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic [WIDTH-1:0] out_q;
   logic             ovr_q;
   logic [CNT_W-1:0] count;
   logic             wrap;
   logic             completion;
   logic             load_out;
   logic             set_ovr;

   bit_cntr #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_cntr (
      .clk   (clk),
      .res   (res),
      .clr   (clr),
      .en    (en),
      .count (count),
      .wrap  (wrap)
   );

   assign completion = wrap;
   assign shreg_nxt  = {d, shreg[WIDTH-1:1]};

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         shreg <= '0;
      end else if (clr) begin
         shreg <= '0;
      end else if (en) begin
         shreg <= shreg_nxt;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next-state logic
   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: if (completion) state_nxt = ST_FULL;
            ST_FULL:  if (ready && !completion) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
         endcase
      end
   end

   // FSM: output decode
   always_comb begin
      valid    = 1'b0;
      load_out = 1'b0;
      set_ovr  = 1'b0;
      case (state)
         ST_EMPTY: begin
            load_out = completion && !clr;
         end
         ST_FULL: begin
            valid    = 1'b1;
            load_out = completion && ready && !clr;
            set_ovr  = completion && !ready && !clr;
         end
         default: begin
            valid = 1'b0;
         end
      endcase
   end

   // out holds through clr; only reset or a delivered word changes it.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         out_q <= '0;
      end else if (load_out) begin
         out_q <= shreg_nxt;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         ovr_q <= 1'b0;
      end else if (clr) begin
         ovr_q <= 1'b0;
      end else if (set_ovr) begin
         ovr_q <= 1'b1;
      end
   end

   assign out = out_q;
   assign ovr = ovr_q;

   a_wrap_consistent : assert property (@(posedge clk) disable iff (res)
      wrap == (en && (count == CNT_W'(WIDTH - 1))));

   a_ovr_sticky : assert property (@(posedge clk) disable iff (res)
      (ovr && !clr) |=> ovr);

   a_valid_drop : assert property (@(posedge clk) disable iff (res)
      (valid && !ready && !clr) |=> valid);

endmodule : sipo_deser

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: a vector table for the handshake/overrun
// scenarios plus hand-written clear, async-reset and gapped-strobe sequences.
module tb_sipo_deser;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         res;
   logic         en;
   logic         d;
   logic         clr;
   logic         ready;
   logic [W-1:0] out;
   logic         valid;
   logic         ovr;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];

   typedef struct {
      logic         en;
      logic         d;
      logic         clr;
      logic         ready;
      logic [W-1:0] exp_out;
      logic         exp_valid;
      logic         exp_ovr;
   } vec_t;

   vec_t vecs[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   sipo_deser #(.WIDTH(W)) dut (
      .clk   (clk),
      .res   (res),
      .en    (en),
      .d     (d),
      .clr   (clr),
      .ready (ready),
      .out   (out),
      .valid (valid),
      .ovr   (ovr)
   );

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic e, input logic b, input logic c, input logic r);
      @(negedge clk);
      en    = e;
      d     = b;
      clr   = c;
      ready = r;
   endtask

   task automatic step(input logic e, input logic b, input logic c, input logic r);
      drive(e, b, c, r);
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic r);
      for (int i = 0; i < W; i++) step(1'b1, w[i], 1'b0, r);
   endtask

   task automatic add(input logic e, input logic b, input logic c, input logic r,
                      input logic [W-1:0] eo, input logic ev, input logic eov);
      vec_t v;
      v.en = e; v.d = b; v.clr = c; v.ready = r;
      v.exp_out = eo; v.exp_valid = ev; v.exp_ovr = eov;
      vecs.push_back(v);
   endtask

   task automatic add_word(input logic [W-1:0] w, input logic rdy_mid, input logic rdy_last,
                           input logic [W-1:0] eo_mid, input logic ev_mid, input logic eov_mid,
                           input logic [W-1:0] eo_last, input logic ev_last, input logic eov_last);
      for (int i = 0; i < W - 1; i++) add(1'b1, w[i], 1'b0, rdy_mid, eo_mid, ev_mid, eov_mid);
      add(1'b1, w[W-1], 1'b0, rdy_last, eo_last, ev_last, eov_last);
   endtask

   // ---------------- test ----------------
   initial begin
      int rises;
      logic prev_valid;
      logic [W-1:0] partial;
      logic [W-1:0] gap_word;
      logic [W-1:0] exp_w;

      res = 1'b1; en = 1'b0; d = 1'b0; clr = 1'b0; ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out",   out,         8'h00);
      check("reset_valid", {7'b0, valid}, 8'h00);
      check("reset_ovr",   {7'b0, ovr},   8'h00);
      @(negedge clk);
      res = 1'b0;

      // A5 lands, consumed; 3C back-to-back with ready high
      add_word(8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
      add_word(8'h3C, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
      // overrun: FF dropped while A5 is held, ovr sticky through ready, cleared by clr
      add_word(8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
      add_word(8'hFF, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
      // 0F completes on the same edge that A5 is consumed
      add_word(8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
      add_word(8'h0F, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].en, vecs[i].d, vecs[i].clr, vecs[i].ready);
         check($sformatf("vec%0d_out", i),   out,            vecs[i].exp_out);
         check($sformatf("vec%0d_valid", i), {7'b0, valid},  {7'b0, vecs[i].exp_valid});
         check($sformatf("vec%0d_ovr", i),   {7'b0, ovr},    {7'b0, vecs[i].exp_ovr});
      end

      // clr mid-word discards the partial bits
      partial = 8'h07;
      for (int i = 0; i < 3; i++) step(1'b1, partial[i], 1'b0, 1'b0);
      check("partial_valid", {7'b0, valid}, 8'h00);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("clr_out_hold", out, 8'h0F);
      check("clr_valid",    {7'b0, valid}, 8'h00);
      exp_q.push_back(8'h81);
      send_word(8'h81, 1'b0);
      exp_w = exp_q.pop_front();
      check("clr_then_81", out, exp_w);
      check("clr_then_81_valid", {7'b0, valid}, 8'h01);
      check("clr_then_81_ovr",   {7'b0, ovr},   8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // asynchronous reset mid-word, sampled before any clock edge
      partial = 8'h02;
      for (int i = 0; i < 3; i++) step(1'b1, partial[i], 1'b0, 1'b0);
      @(negedge clk);
      en = 1'b0;
      #2 res = 1'b1;
      #1;
      check("async_res_out",   out, 8'h00);
      check("async_res_valid", {7'b0, valid}, 8'h00);
      @(negedge clk);
      res = 1'b0;
      exp_q.push_back(8'h81);
      send_word(8'h81, 1'b0);
      exp_w = exp_q.pop_front();
      check("res_then_81", out, exp_w);
      check("res_then_81_valid", {7'b0, valid}, 8'h01);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("res_then_81_consumed", {7'b0, valid}, 8'h00);

      // C3 with random idle gaps between strobes
      gap_word = 8'hC3;
      exp_q.push_back(gap_word);
      rises = 0;
      prev_valid = valid;
      for (int i = 0; i < W; i++) begin
         int gap;
         gap = $urandom_range(0, 5);
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (valid && !prev_valid) rises++;
            prev_valid = valid;
         end
         step(1'b1, gap_word[i], 1'b0, 1'b0);
         if (valid && !prev_valid) rises++;
         prev_valid = valid;
      end
      for (int g = 0; g < 3; g++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (valid && !prev_valid) rises++;
         prev_valid = valid;
      end
      exp_w = exp_q.pop_front();
      check("gap_out",   out, exp_w);
      check("gap_rises", 8'(rises), 8'd1);
      check("gap_ovr",   {7'b0, ovr}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sipo_deser
